button_pulse_conditioner: RTL and testbench

- Upstream stage of the mode-control FSM: turns three raw push-button inputs into clean single-cycle request pulses that drive the FSM inputs Ain, Bin and Cin directly.
- Per channel: 2-flop synchroniser, counter-based debouncer, rising-edge one-shot.
- A fixed-priority arbiter guarantees at most one of Ain/Bin/Cin is high in any cycle. Simultaneous presses are serialised, never lost.

---
 rtl/button_pulse_conditioner.sv | 90 +++++++++
 tb/tb_button_pulse_conditioner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_conditioner.sv
// Conditions three raw push-buttons into single-cycle request pulses (Ain/Bin/Cin).
// Each channel is synchronised, debounced and edge-detected; a fixed a>b>c arbiter serialises pulses.
module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  output logic       Ain,
  output logic       Bin,
  output logic       Cin,
  output logic [2:0] btn_lvl,
  output logic [2:0] pend
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       btn_raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       stable;
  logic [2:0]       qualify;
  logic [2:0]       rise;
  logic [2:0]       grant;

  function automatic logic [2:0] pick(input logic [2:0] req);
    if (req[0])      return 3'b001;
    else if (req[1]) return 3'b010;
    else if (req[2]) return 3'b100;
    else             return 3'b000;
  endfunction

  assign btn_raw = {btn_c, btn_b, btn_a};

  // Stage 0/1: two-flop synchroniser per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    qualify = '0;
    for (int i = 0; i < 3; i++)
      qualify[i] = (sync_p1[i] != stable[i]) && (cnt[i] == CNT_LAST);
    rise  = qualify & sync_p1;
    grant = pick(pend);
  end

  // Stage 2: debounce counters and accepted stable levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (qualify[i]) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_lvl = stable;

  // Stage 3: pending flags and arbitrated pulses; a new rise outranks a same-edge grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend           <= '0;
      {Cin, Bin, Ain} <= '0;
    end else begin
      pend           <= (pend & ~grant) | rise;
      {Cin, Bin, Ain} <= grant;
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with a pulse scoreboard (edge index + channel).
module tb_button_pulse_conditioner;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;  // drive after edge k -> pulse sampled after edge k+LAT

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_a, btn_b, btn_c;
  logic       Ain, Bin, Cin;
  logic [2:0] btn_lvl;
  logic [2:0] pend;

  typedef struct {
    int         cyc;
    logic [2:0] ch;
  } pulse_t;

  pulse_t exp_q[$];
  int     edge_cnt = 0;
  int     tests    = 0;
  int     fails    = 0;

  button_pulse_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .Ain(Ain), .Bin(Bin), .Cin(Cin), .btn_lvl(btn_lvl), .pend(pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] ch, input int lat);
    pulse_t p;
    p.cyc = edge_cnt + lat;
    p.ch  = ch;
    exp_q.push_back(p);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    pulse_t     p;
    logic [2:0] outs;
    outs = {Cin, Bin, Ain};
    tests++;
    assert ($countones(outs) <= 1) else begin
      fails++;
      $error("FAIL onehot observed=%b expected=at_most_one", outs);
    end
    if (outs != 3'b000) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_pulse observed=%b@%0d expected=none", outs, edge_cnt);
      end else begin
        p = exp_q.pop_front();
        tests++;
        assert (outs === p.ch && edge_cnt === p.cyc) else begin
          fails++;
          $error("FAIL pulse observed=%b@%0d expected=%b@%0d", outs, edge_cnt, p.ch, p.cyc);
        end
      end
    end
  end

  initial begin
    // 1: button held through reset release
    rst = 1'b1; btn_a = 1'b1; btn_b = 1'b0; btn_c = 1'b0;
    #1;
    chk("rst_outs", {29'd0, Cin, Bin, Ain}, 0);
    chk("rst_lvl", {29'd0, btn_lvl}, 0);
    chk("rst_pend", {29'd0, pend}, 0);
    step(2);
    chk("rst_outs2", {29'd0, Cin, Bin, Ain}, 0);
    chk("rst_pend2", {29'd0, pend}, 0);
    rst = 1'b0;
    expect_pulse(3'b001, LAT);
    step(LAT + 3);
    chk("t1_q", exp_q.size(), 0);
    btn_a = 1'b0;
    step(10);
    chk("t1_release_lvl", {29'd0, btn_lvl}, 0);

    // 2: clean press of B, held
    btn_b = 1'b1;
    expect_pulse(3'b010, LAT);
    step(5);
    chk("t2_lvl_before", {31'd0, btn_lvl[1]}, 0);
    step(1);
    chk("t2_lvl_rise", {31'd0, btn_lvl[1]}, 1);
    chk("t2_pend", {29'd0, pend}, 3'b010);
    step(1);
    chk("t2_bin", {31'd0, Bin}, 1);
    step(1);
    chk("t2_bin_low", {31'd0, Bin}, 0);
    step(16);
    chk("t2_q", exp_q.size(), 0);
    btn_b = 1'b0;
    step(10);

    // 3: bounce on A, then held
    btn_a = 1'b1; step(1);
    btn_a = 1'b0; step(1);
    btn_a = 1'b1; step(1);
    btn_a = 1'b0; step(1);
    btn_a = 1'b1;
    expect_pulse(3'b001, LAT);
    step(5);
    chk("t3_no_early", {29'd0, pend}, 0);
    step(LAT);
    chk("t3_q", exp_q.size(), 0);
    btn_a = 1'b0;
    step(10);

    // 4: simultaneous press on all three
    btn_a = 1'b1; btn_b = 1'b1; btn_c = 1'b1;
    expect_pulse(3'b001, LAT);
    expect_pulse(3'b010, LAT + 1);
    expect_pulse(3'b100, LAT + 2);
    step(6);
    chk("t4_pend_all", {29'd0, pend}, 3'b111);
    step(1);
    chk("t4_pend_after_a", {29'd0, pend}, 3'b110);
    step(5);
    chk("t4_q", exp_q.size(), 0);
    btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
    step(10);

    // 5: release and re-press C, then a too-short release
    btn_c = 1'b1;
    expect_pulse(3'b100, LAT);
    step(10);
    btn_c = 1'b0;
    step(6);
    chk("t5_lvl_fall", {31'd0, btn_lvl[2]}, 0);
    btn_c = 1'b1;
    expect_pulse(3'b100, LAT);
    step(10);
    btn_c = 1'b0;
    step(2);
    btn_c = 1'b1;
    step(8);
    chk("t5_lvl_held", {31'd0, btn_lvl[2]}, 1);
    chk("t5_q", exp_q.size(), 0);
    btn_c = 1'b0;
    step(10);

    // 6: reset with pending requests, buttons released during reset
    btn_a = 1'b1; btn_b = 1'b1;
    step(6);
    chk("t6_pend_pre", {29'd0, pend}, 3'b011);
    rst = 1'b1;
    #1;
    chk("t6_pend_rst", {29'd0, pend}, 0);
    chk("t6_lvl_rst", {29'd0, btn_lvl}, 0);
    step(1);
    btn_a = 1'b0; btn_b = 1'b0;
    step(2);
    rst = 1'b0;
    step(15);
    chk("t6_pend_after", {29'd0, pend}, 0);
    chk("final_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
